// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - single leaky integrate-and-fire neuron with registered spike output
// Optional post-spike dead time is enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_core #(
   parameter int MEMBRANE_THRESHOLD       = 8,
   parameter int MEMBRANE_DECAY           = 1,
   parameter int MEMBRANE_POTENTIAL_WIDTH = 8,
   parameter int REFRACTORY_CYCLES        = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [MEMBRANE_POTENTIAL_WIDTH-1:0] synaptic_input,
   output logic                                spike_output
);

   localparam int W = MEMBRANE_POTENTIAL_WIDTH;
   localparam logic [W:0] THRESH_EXT = (W+1)'(MEMBRANE_THRESHOLD);
   localparam logic [W:0] DECAY_EXT  = (W+1)'(MEMBRANE_DECAY);

   logic [W-1:0] membrane_potential;
   logic [W-1:0] leaked;
   logic [W:0]   sum;
   logic         fire;

   // Leak floors at zero; the sum keeps its carry so an all-ones input still fires.
   always_comb begin
      leaked = '0;
      if ({1'b0, membrane_potential} > DECAY_EXT)
         leaked = membrane_potential - DECAY_EXT[W-1:0];
      sum  = {1'b0, leaked} + {1'b0, synaptic_input};
      fire = (sum >= THRESH_EXT);
   end

`ifdef LIF_REFRACTORY_EN
   localparam int RW = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
   localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACTORY_CYCLES);

   logic [RW-1:0] refr_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         membrane_potential <= '0;
         spike_output       <= 1'b0;
         refr_count         <= '0;
      end else if (refr_count != '0) begin
         membrane_potential <= '0;
         spike_output       <= 1'b0;
         refr_count         <= refr_count - 1'b1;
      end else if (fire) begin
         membrane_potential <= '0;
         spike_output       <= 1'b1;
         refr_count         <= REFR_LOAD;
      end else begin
         membrane_potential <= sum[W-1:0];
         spike_output       <= 1'b0;
      end
   end
`else
   // Dead time is absent in this build; a negative setting would still be nonsensical.
   if (REFRACTORY_CYCLES < 0) begin : g_refr_unused
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         membrane_potential <= '0;
         spike_output       <= 1'b0;
      end else if (fire) begin
         membrane_potential <= '0;
         spike_output       <= 1'b1;
      end else begin
         membrane_potential <= sum[W-1:0];
         spike_output       <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb/tb_lif_neuron_core.sv - randomized and directed checks of lif_neuron_core against a behavioural model
module tb_lif_neuron_core;

   localparam int W    = 8;
   localparam int TH   = 8;
   localparam int DEC  = 1;
   localparam int REFR = 2;
`ifdef LIF_REFRACTORY_EN
   localparam bit REFR_EN = 1'b1;
`else
   localparam bit REFR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] synaptic_input = '0;
   logic         spike_output;

   int vectors     = 0;
   int compares    = 0;
   int miscompares = 0;
   bit checking    = 1'b0;

   int exp_pot  = 0;
   int exp_spk  = 0;
   int exp_refr = 0;

   lif_neuron_core #(
      .MEMBRANE_THRESHOLD       (TH),
      .MEMBRANE_DECAY           (DEC),
      .MEMBRANE_POTENTIAL_WIDTH (W),
      .REFRACTORY_CYCLES        (REFR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .synaptic_input (synaptic_input),
      .spike_output   (spike_output)
   );

   always #5 clk = ~clk;

   // Model neuron: plain integer arithmetic straight from the firing rules.
   task automatic model_update(input bit r, input int x);
      int leaked, s;
      if (r) begin
         exp_pot = 0; exp_spk = 0; exp_refr = 0;
      end else if (REFR_EN && exp_refr > 0) begin
         exp_pot = 0; exp_spk = 0; exp_refr = exp_refr - 1;
      end else begin
         leaked = (exp_pot > DEC) ? exp_pot - DEC : 0;
         s = leaked + x;
         if (s >= TH) begin
            exp_pot = 0; exp_spk = 1; exp_refr = REFR;
         end else begin
            exp_pot = s; exp_spk = 0;
         end
      end
   endtask

   task automatic step(input bit r, input int x);
      reset = r;
      synaptic_input = x[W-1:0];
      @(posedge clk);
      model_update(r, x);
      vectors++;
      checking = 1'b1;
      #1;
   endtask

   task automatic lit(input string name, input int spk, input int pot);
      compares++;
      if (int'(spike_output) != spk || int'(dut.membrane_potential) != pot) begin
         miscompares++;
         $display("FAIL %s: got spike=%0d pot=%0d, want spike=%0d pot=%0d",
                  name, spike_output, dut.membrane_potential, spk, pot);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         compares++;
         if (int'(spike_output) != exp_spk || int'(dut.membrane_potential) != exp_pot) begin
            miscompares++;
            $display("FAIL model t=%0t: got spike=%0d pot=%0d, want spike=%0d pot=%0d",
                     $time, spike_output, dut.membrane_potential, exp_spk, exp_pot);
         end
      end
   end

   initial begin
      step(1, 0);
      lit("reset", 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0);
      lit("idle_zero", 0, 0);

`ifndef LIF_REFRACTORY_EN
      for (int i = 0; i < 5; i++) step(0, 1);
      lit("hold_one", 0, 1);
      step(0, 3); lit("ramp3_a", 0, 3);
      step(0, 3); lit("ramp3_b", 0, 5);
      step(0, 3); lit("ramp3_c", 0, 7);
      step(0, 3); lit("ramp3_spike", 1, 0);
      step(0, 3); lit("ramp3_again", 0, 3);
      for (int i = 0; i < 3; i++) begin step(0, 8);  lit("hold8", 1, 0);  end
      for (int i = 0; i < 3; i++) begin step(0, 10); lit("hold10", 1, 0); end

      step(1, 0);
      step(0, 3); step(0, 3); step(0, 3);
      lit("pot7", 0, 7);
      for (int p = 6; p >= 0; p--) begin step(0, 0); lit("decay", 0, p); end
      step(0, 0); lit("floor0", 0, 0);
      step(0, 5); lit("in5", 0, 5);
      step(0, 8); lit("in8_fire", 1, 0);

      step(0, 0); step(0, 0);
      step(0, 255); lit("allones", 1, 0);
      step(0, 3); step(0, 3); lit("mid_int", 0, 5);
      step(1, 3); lit("mid_reset", 0, 0);
`else
      step(0, 8); lit("refr_spike1", 1, 0);
      step(0, 8); lit("refr_quiet1", 0, 0);
      step(0, 8); lit("refr_quiet2", 0, 0);
      step(0, 8); lit("refr_spike2", 1, 0);
      step(1, 8); lit("refr_reset", 0, 0);
      step(0, 8); lit("refr_after_reset", 1, 0);
`endif

      for (int i = 0; i < 400; i++) begin
         int sel, x;
         sel = $urandom_range(0, 9);
         if (sel < 6)      x = $urandom_range(0, 4);
         else if (sel < 9) x = $urandom_range(0, 12);
         else              x = $urandom_range(0, 255);
         step(($urandom_range(0, 49) == 0), x);
      end

      checking = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
